// File: rtl/return_address_stack_pkg.sv
// Shared constants and the resolved-branch packet used by the return address stack.
// RAS_DEPTH and br_results_t mirror the core's cva5_config / cva5_types definitions.
package return_address_stack_pkg;

   localparam int RAS_DEPTH = 8;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] target;
      logic        is_branch;
      logic        is_call;
      logic        is_return;
      logic        branch_taken;
   } br_results_t;

endpackage

// File: rtl/return_address_stack_if.sv
// Fetch/branch-unit side bundle of the return address stack.
// master = fetch and branch logic driving predictions, slave = the stack itself.
interface return_address_stack_if;
   import return_address_stack_pkg::*;

   logic        fetch_push;
   logic [31:0] fetch_push_addr;
   logic        fetch_pop;
   br_results_t br_results;
   logic        branch_flush;
   logic [31:0] ras_top;
   logic        ras_valid;

   modport master (
      output fetch_push, fetch_push_addr, fetch_pop, br_results, branch_flush,
      input  ras_top, ras_valid
   );

   modport slave (
      input  fetch_push, fetch_push_addr, fetch_pop, br_results, branch_flush,
      output ras_top, ras_valid
   );

endinterface

// File: rtl/lutram_1w_1r.sv
// Distributed RAM with one synchronous write port and one asynchronous read port.
// Read data is combinational from raddr; contents are not reset.
module lutram_1w_1r
   #(
      parameter int WIDTH = 32,
      parameter int DEPTH = 8
   )
   (
      input  logic                     clk,
      input  logic [$clog2(DEPTH)-1:0] waddr,
      input  logic [$clog2(DEPTH)-1:0] raddr,
      input  logic                     ram_write,
      input  logic [WIDTH-1:0]         new_ram_data,
      output logic [WIDTH-1:0]         ram_data_out
   );

   logic [WIDTH-1:0] ram [DEPTH];

   always_ff @(posedge clk) begin
      if (ram_write)
         ram[waddr] <= new_ram_data;
   end

   assign ram_data_out = ram[raddr];

endmodule

// File: rtl/return_address_stack.sv
// Speculative return address stack with a committed shadow copy for misprediction recovery.
// Zero-cycle top read; pushes visible next cycle; flush restores pointers but not storage.
module return_address_stack
   import return_address_stack_pkg::*;
   #(
      parameter int DEPTH = RAS_DEPTH
   )
   (
      input  logic                   clk,
      input  logic                   rst,
      return_address_stack_if.slave  ras
   );

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [PTR_W-1:0] spec_ptr, spec_ptr_next;
   logic [CNT_W-1:0] spec_count, spec_count_next;
   logic [PTR_W-1:0] commit_ptr, commit_ptr_next;
   logic [CNT_W-1:0] commit_count, commit_count_next;

   logic             ram_write;
   logic [PTR_W-1:0] waddr;
   logic             unused_br;

   assign unused_br = ^{ras.br_results.pc, ras.br_results.target,
                        ras.br_results.is_branch, ras.br_results.branch_taken};

   // Shared pointer/count rule for both copies; push+pop replaces the top in place.
   function automatic logic [PTR_W+CNT_W-1:0] stack_step(
      input logic             push,
      input logic             pop,
      input logic [PTR_W-1:0] ptr,
      input logic [CNT_W-1:0] cnt
   );
      logic [PTR_W-1:0] p;
      logic [CNT_W-1:0] c;
      p = ptr;
      c = cnt;
      if (push && pop) begin
         if (cnt == '0)
            c = CNT_W'(1);
      end else if (push) begin
         p = ptr + PTR_W'(1);
         if (cnt != FULL)
            c = cnt + CNT_W'(1);
      end else if (pop && (cnt != '0)) begin
         p = ptr - PTR_W'(1);
         c = cnt - CNT_W'(1);
      end
      return {p, c};
   endfunction

   always_comb begin
      commit_ptr_next   = commit_ptr;
      commit_count_next = commit_count;
      if (ras.br_results.valid)
         {commit_ptr_next, commit_count_next} = stack_step(ras.br_results.is_call,
            ras.br_results.is_return, commit_ptr, commit_count);

      if (ras.branch_flush) begin
         spec_ptr_next   = commit_ptr_next;
         spec_count_next = commit_count_next;
      end else begin
         {spec_ptr_next, spec_count_next} = stack_step(ras.fetch_push, ras.fetch_pop,
            spec_ptr, spec_count);
      end
   end

   // Wrong-path pushes still land in storage; only the pointers are rolled back on flush.
   assign ram_write = rst && !ras.branch_flush && ras.fetch_push;
   assign waddr     = ras.fetch_pop ? spec_ptr : spec_ptr + PTR_W'(1);

   always_ff @(posedge clk) begin
      if (!rst) begin
         spec_ptr     <= '0;
         spec_count   <= '0;
         commit_ptr   <= '0;
         commit_count <= '0;
      end else begin
         spec_ptr     <= spec_ptr_next;
         spec_count   <= spec_count_next;
         commit_ptr   <= commit_ptr_next;
         commit_count <= commit_count_next;
      end
   end

   lutram_1w_1r #(
      .WIDTH (32),
      .DEPTH (DEPTH)
   ) ras_ram (
      .clk          (clk),
      .waddr        (waddr),
      .raddr        (spec_ptr),
      .ram_write    (ram_write),
      .new_ram_data (ras.fetch_push_addr),
      .ram_data_out (ras.ras_top)
   );

   assign ras.ras_valid = (spec_count != '0);

endmodule

// File: tb/tb_return_address_stack.sv
// Randomised plus directed bench for return_address_stack with a queue-based reference model.
module tb_return_address_stack;
   import return_address_stack_pkg::*;

   localparam int D = 8;

   logic clk;
   logic rst;

   return_address_stack_if ras_bus ();

   return_address_stack #(.DEPTH(D)) dut (
      .clk (clk),
      .rst (rst),
      .ras (ras_bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] top;
      bit          top_known;
      bit          valid;
      int          count;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   fails  = 0;

   // Reference model: circular array with integer pointers and modulo arithmetic.
   logic [31:0] mem   [D];
   bit          known [D];
   int          sp = 0, sc = 0, cp = 0, cc = 0;

   task automatic apply_rule(input bit psh, input bit pp, inout int p, inout int c);
      if (psh && pp) begin
         if (c == 0) c = 1;
      end else if (psh) begin
         p = (p + 1) % D;
         c = (c < D) ? c + 1 : D;
      end else if (pp && c > 0) begin
         p = (p + D - 1) % D;
         c = c - 1;
      end
   endtask

   task automatic model(input bit rn, input bit psh, input logic [31:0] a, input bit pp,
                        input bit bv, input bit bc, input bit br, input bit fl);
      exp_t e;
      if (!rn) begin
         sp = 0; sc = 0; cp = 0; cc = 0;
      end else begin
         if (bv) apply_rule(bc, br, cp, cc);
         if (fl) begin
            sp = cp;
            sc = cc;
         end else begin
            if (psh && pp) begin
               mem[sp] = a; known[sp] = 1'b1;
            end else if (psh) begin
               mem[(sp + 1) % D] = a; known[(sp + 1) % D] = 1'b1;
            end
            apply_rule(psh, pp, sp, sc);
         end
      end
      e.top       = mem[sp];
      e.top_known = known[sp];
      e.valid     = (sc != 0);
      e.count     = sc;
      exp_q.push_back(e);
   endtask

   task automatic cyc(input bit rn, input bit psh, input logic [31:0] a, input bit pp,
                      input bit bv, input bit bc, input bit br, input bit fl);
      br_results_t b;
      b = '0;
      b.valid     = bv;
      b.is_call   = bc;
      b.is_return = br;
      b.pc        = $urandom;
      b.target    = $urandom;
      rst                     = rn;
      ras_bus.fetch_push      = psh;
      ras_bus.fetch_push_addr = a;
      ras_bus.fetch_pop       = pp;
      ras_bus.br_results      = b;
      ras_bus.branch_flush    = fl;
      @(posedge clk);
      model(rn, psh, a, pp, bv, bc, br, fl);
      #1;
   endtask

   task automatic idle();
      cyc(1, 0, 32'h0, 0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
      cyc(0, 0, 32'h0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: one expected record per clock, compared half a cycle after the update.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (ras_bus.ras_valid !== e.valid) begin
               fails++;
               $display("FAIL ras_valid @%0t: got %0b expected %0b", $time, ras_bus.ras_valid, e.valid);
            end
            checks++;
            if (int'(dut.spec_count) != e.count) begin
               fails++;
               $display("FAIL spec_count @%0t: got %0d expected %0d", $time, dut.spec_count, e.count);
            end
            if (e.top_known) begin
               checks++;
               if (ras_bus.ras_top !== e.top) begin
                  fails++;
                  $display("FAIL ras_top @%0t: got %h expected %h", $time, ras_bus.ras_top, e.top);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < D; i++) known[i] = 1'b0;
      rst = 1'b0;
      ras_bus.fetch_push = 1'b0;
      ras_bus.fetch_push_addr = '0;
      ras_bus.fetch_pop = 1'b0;
      ras_bus.br_results = '0;
      ras_bus.branch_flush = 1'b0;

      // push/push/pop/pop basic ordering
      do_reset();
      cyc(1, 1, 32'h100, 0, 0, 0, 0, 0);
      cyc(1, 1, 32'h200, 0, 0, 0, 0, 0);
      idle();
      cyc(1, 0, 32'h0, 1, 0, 0, 0, 0);
      cyc(1, 0, 32'h0, 1, 0, 0, 0, 0);
      idle();

      // overflow wrap then drain past empty
      do_reset();
      for (int i = 1; i <= 9; i++) cyc(1, 1, 32'(i * 16), 0, 0, 0, 0, 0);
      for (int i = 0; i < 9; i++) cyc(1, 0, 32'h0, 1, 0, 0, 0, 0);
      idle();

      // co-routine push+pop
      do_reset();
      cyc(1, 1, 32'h100, 0, 0, 0, 0, 0);
      cyc(1, 1, 32'h300, 1, 0, 0, 0, 0);
      idle();
      do_reset();
      cyc(1, 1, 32'h400, 1, 0, 0, 0, 0);
      idle();

      // committed call, wrong-path pushes, flush
      do_reset();
      cyc(1, 1, 32'h100, 0, 1, 1, 0, 0);
      cyc(1, 1, 32'h200, 0, 0, 0, 0, 0);
      cyc(1, 1, 32'h300, 0, 0, 0, 0, 0);
      cyc(1, 0, 32'h0, 0, 0, 0, 0, 1);
      idle();

      // flush with same-cycle committed return; fetch push ignored
      do_reset();
      cyc(1, 1, 32'h111, 0, 1, 1, 0, 0);
      cyc(1, 1, 32'h222, 0, 1, 1, 0, 0);
      cyc(1, 1, 32'hdead, 0, 1, 0, 1, 1);
      idle();

      // reset overrides push and flush
      do_reset();
      cyc(1, 1, 32'h500, 0, 1, 1, 0, 0);
      cyc(1, 1, 32'h600, 0, 0, 0, 0, 0);
      cyc(0, 1, 32'h700, 0, 1, 1, 0, 1);
      idle();

      // random traffic
      for (int n = 0; n < 3000; n++) begin
         bit rn, psh, pp, bv, bc, br, fl;
         rn  = ($urandom_range(0, 99) >= 1);
         psh = ($urandom_range(0, 99) < 40);
         pp  = ($urandom_range(0, 99) < 35);
         bv  = ($urandom_range(0, 99) < 30);
         bc  = ($urandom_range(0, 1) == 1);
         br  = ($urandom_range(0, 1) == 1);
         fl  = ($urandom_range(0, 99) < 8);
         cyc(rn, psh, $urandom, pp, bv, bc, br, fl);
      end
      idle();

      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      #1;
      checks++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d records left, expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

// File: doc/return_address_stack.md
RETURN_ADDRESS_STACK -- requirements
Module: return_address_stack

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning the number of stack entries; legal values are powers of two, 2 to 64.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; it is synchronous and active-low.
REQ-004 SHALL have port fetch_push, input, 1, meaning fetch predicts a call this cycle.
REQ-005 SHALL have port fetch_push_addr, input, 32, meaning the return address (call PC + 4) to push.
REQ-006 SHALL have port fetch_pop, input, 1, meaning fetch predicts a return this cycle.
REQ-007 SHALL have port br_results, input, br_results_t, the resolved branch packet from the branch unit; only the valid, is_call and is_return fields are used.
REQ-008 SHALL have port branch_flush, input, 1, meaning a branch misprediction redirect this cycle.
REQ-009 SHALL have port ras_top, output, 32, meaning the speculative top-of-stack return address.
REQ-010 SHALL have port ras_valid, output, 1, meaning the speculative stack holds at least one entry.

Function
REQ-011 SHALL keep speculative state (spec_ptr, spec_count) and committed state (commit_ptr, commit_count): pointers log2(DEPTH) bits and wrap modulo DEPTH; counts range 0..DEPTH.
REQ-012 SHALL drive ras_top combinationally as stack[spec_ptr] from registered state, with zero-cycle read latency.
REQ-013 SHALL drive ras_valid = (spec_count != 0).
REQ-014 SHALL handle a fetch push only (no flush): write fetch_push_addr to stack[spec_ptr+1], increment spec_ptr, count saturates at DEPTH (oldest entry overwritten on wrap); the new value appears on ras_top the next cycle.
REQ-015 SHALL handle a fetch pop only: decrement spec_ptr and spec_count when spec_count != 0; at spec_count == 0, leave state unchanged.
REQ-016 SHALL handle fetch push and pop together (a co-routine JALR) by overwriting stack[spec_ptr] with fetch_push_addr, with spec_ptr and spec_count unchanged, including at count 0, where count becomes 1.
REQ-017 SHALL update committed state on br_results.valid using the same push, pop and push+pop pointer/count rules keyed on is_call/is_return; committed state never writes the storage array.
REQ-018 SHALL, on branch_flush, load spec_ptr/spec_count with the committed state as updated by any br_results.valid in the same cycle (the next-state value); fetch push/pop in that cycle are ignored.
REQ-019 SHALL keep the storage array unchanged on flush; entries overwritten by wrong-path pushes are not restored.
REQ-020 SHALL ignore branch_flush in a cycle without br_results.valid only in its effect on committed state; spec state is still restored from commit state.

Reset
REQ-021 SHALL, while rst is low at a clock edge, clear spec_ptr, spec_count, commit_ptr and commit_count to 0.
REQ-022 SHALL give ras_valid a reset value of 0; ras_top after reset is stack[0], storage is not reset and its contents are undefined.
REQ-023 SHALL have reset override flush, push and pop in the same cycle; a reset mid-sequence discards all speculative and committed history.

Structure
REQ-024 SHALL take DEPTH from a RAS_DEPTH constant in cva5_config; br_results_t remains in cva5_types, and no new types are required.
REQ-025 SHALL implement the storage as one lutram_1w_1r instance (write port for pushes, read port addressed by spec_ptr); pointer/count logic is local.

Verification
REQ-026 SHALL cover push 0x100, push 0x200 -> ras_top 0x200 next cycle; pop -> ras_top 0x100, ras_valid 1; pop -> ras_valid 0.
REQ-027 SHALL cover DEPTH=8 with 9 pushes of 0x10..0x90 -> spec_count 8; 8 pops return 0x90..0x20, then ras_valid 0; a further pop leaves state unchanged.
REQ-028 SHALL cover push 0x100 then push+pop of 0x300 in one cycle -> ras_top 0x300, count 1.
REQ-029 SHALL cover a committed call (br valid, is_call) for push 0x100, then wrong-path push 0x200 and push 0x300, then branch_flush -> ras_top 0x100, count 1.
REQ-030 SHALL cover flush coinciding with br valid+is_return while committed count is 2 -> spec_count 1; a fetch push in that cycle is ignored.
REQ-031 SHALL cover rst low during pushes with a simultaneous flush -> ras_valid 0 the next cycle, and all counts 0.
